// File: rtl/matrix_stream_controller.sv
// Byte-stream front end for the 5x5 signed 8-bit matrix multiplier: packs 50 operand
// bytes, runs one 5-row multiplier pass, then streams the 25 result bytes out.
module matrix_stream_controller #(
   parameter int WAIT_LIMIT = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   output logic [199:0] matrix_a,
   output logic [199:0] matrix_b,
   output logic         start,
   input  logic         done,
   input  logic [199:0] result,
   output logic         out_valid,
   output logic [7:0]   out_data,
   input  logic         out_ready,
   output logic         out_last,
   output logic         busy,
   output logic         err
);
   // state   | meaning
   // S_LOAD    | accepting operand bytes 0..49
   // S_COMPUTE | start held high for one 5-row multiplier pass
   // S_WAIT    | waiting for done, bounded by WAIT_LIMIT
   // S_DRAIN   | streaming the 25 captured result bytes
   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_WAIT, S_DRAIN} state_t;

   localparam int WW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

   state_t        state;
   logic [5:0]    byte_idx;
   logic [4:0]    wr_elem;
   logic [4:0]    out_idx;
   logic [2:0]    pass_cnt;
   logic [WW-1:0] wait_tmr;
   logic [199:0]  shadow;

   always_comb begin
      wr_elem = byte_idx[4:0];
      if (byte_idx >= 6'd25) wr_elem = 5'(byte_idx - 6'd25);
   end

   assign out_data = shadow[{out_idx, 3'b000} +: 8];
   assign out_last = out_valid && (out_idx == 5'd24);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_LOAD;
         in_ready  <= 1'b1;
         start     <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         matrix_a  <= '0;
         matrix_b  <= '0;
         shadow    <= '0;
         byte_idx  <= '0;
         out_idx   <= '0;
         pass_cnt  <= '0;
         wait_tmr  <= '0;
      end else begin
         case (state)
            S_LOAD: begin
               if (in_valid && in_ready) begin
                  if (byte_idx < 6'd25) matrix_a[{wr_elem, 3'b000} +: 8] <= in_data;
                  else                  matrix_b[{wr_elem, 3'b000} +: 8] <= in_data;
                  if (byte_idx == 6'd49) begin
                     byte_idx <= '0;
                     pass_cnt <= '0;
                     start    <= 1'b1;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                     state    <= S_COMPUTE;
                  end else begin
                     byte_idx <= byte_idx + 6'd1;
                  end
               end
            end
            S_COMPUTE: begin
               // a sixth start edge would restart the multiplier at row 0
               if (pass_cnt == 3'd4) begin
                  start    <= 1'b0;
                  wait_tmr <= WW'(WAIT_LIMIT - 1);
                  state    <= S_WAIT;
               end else begin
                  pass_cnt <= pass_cnt + 3'd1;
               end
            end
            S_WAIT: begin
               if (done || wait_tmr == '0) begin
                  if (!done) err <= 1'b1;
                  shadow    <= result;
                  out_idx   <= '0;
                  out_valid <= 1'b1;
                  state     <= S_DRAIN;
               end else begin
                  wait_tmr <= wait_tmr - WW'(1);
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (out_idx == 5'd24) begin
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                     byte_idx  <= '0;
                     state     <= S_LOAD;
                  end else begin
                     out_idx <= out_idx + 5'd1;
                  end
               end
            end
            default: state <= S_LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_matrix_stream_controller.sv
// Scoreboard bench for matrix_stream_controller with a behavioural 5-row multiplier.
module tb_matrix_stream_controller;
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [7:0]   in_data = 8'h00;
   logic         in_ready;
   logic [199:0] matrix_a, matrix_b, result;
   logic         start, done;
   logic         out_valid, out_ready, out_last, busy, err;
   logic [7:0]   out_data;

   int errors = 0, checks = 0, cyc = 0, acc_cyc = 0, pops = 0, ready_mode = 0;
   bit kill_done = 1'b0;
   logic [8:0] exp_q[$];

   logic [2:0]   mrow = 3'd0;
   logic         mdone = 1'b0;
   logic [199:0] mres = '0;
   assign done   = mdone;
   assign result = mres;

   matrix_stream_controller #(.WAIT_LIMIT(4)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .matrix_a(matrix_a), .matrix_b(matrix_b), .start(start),
      .done(done), .result(result), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .out_last(out_last), .busy(busy), .err(err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic [199:0] matmul(input logic [199:0] a, input logic [199:0] b);
      logic [199:0] r;
      int s;
      r = '0;
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            s = 0;
            for (int k = 0; k < 5; k++)
               s += int'($signed(a[i*40+k*8 +: 8])) * int'($signed(b[k*40+j*8 +: 8]));
            r[i*40+j*8 +: 8] = s[7:0];
         end
      return r;
   endfunction

   // multiplier: one row per start edge, done after row 4, row counter never reset
   always @(posedge clock) begin
      if (start) begin
         if (mrow == 3'd4) begin
            mrow  <= 3'd0;
            mdone <= !kill_done;
            mres  <= matmul(matrix_a, matrix_b);
         end else begin
            if (mrow == 3'd0) mdone <= 1'b0;
            mrow <= mrow + 3'd1;
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic chk_w(input string name, input logic [199:0] act, input logic [199:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int sb(input int v);
      return (v > 127) ? v - 256 : v;
   endfunction

   task automatic ref_push(input int a[25], input int b[25]);
      int s;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++) begin
            s = 0;
            for (int k = 0; k < 5; k++) s += sb(a[r*5+k]) * sb(b[k*5+c]);
            exp_q.push_back({(r == 4 && c == 4), s[7:0]});
         end
   endtask

   task automatic send_job(input int a[25], input int b[25], input bit drop);
      int bytes[50];
      int k, guard;
      for (int i = 0; i < 25; i++) begin
         bytes[i]      = a[i];
         bytes[i + 25] = b[i];
      end
      ref_push(a, b);
      k = 0;
      guard = 0;
      while (k < 50 && guard < 2000) begin
         in_valid = drop ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_data  = 8'(bytes[k]);
         @(negedge clock);
         if (in_valid && in_ready) begin
            if (k == 49) acc_cyc = cyc + 1;
            k++;
         end
         @(posedge clock); #1;
         guard++;
      end
      chk("all 50 bytes accepted", k, 50);
      // junk offered while busy must be ignored
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      do begin
         @(negedge clock);
         g++;
      end while (!(exp_q.size() == 0 && in_ready && !out_valid) && g < 1000);
      chk("job drained in time", int'(g < 1000), 1);
      @(posedge clock); #1;
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clock); #1;
         case (ready_mode)
            1:       out_ready = !out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
         endcase
      end
   end

   // monitor / scoreboard
   initial begin
      int start_run = 0;
      bit prev_stall = 1'b0, prev_ov = 1'b0, prev_err = 1'b0;
      logic [8:0] prev_out = '0;
      logic [8:0] e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (out_valid && prev_stall)
               chk("data stable while stalled", int'({out_last, out_data}), int'(prev_out));
            if (out_valid && !prev_ov)
               chk("first out_valid cycles after accept", cyc - acc_cyc, kill_done ? 9 : 6);
            if (err && !prev_err)
               chk("err rise cycles after accept", cyc - acc_cyc, kill_done ? 9 : -1);
            if (out_valid)
               chk("busy=1 in_ready=0 while draining", int'({busy, in_ready}), 2);
            if (start) begin
               start_run++;
               chk("busy during start", int'(busy), 1);
            end else if (start_run != 0) begin
               chk("start high cycles", start_run, 5);
               start_run = 0;
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected output byte", int'({out_last, out_data}), -1);
               end else begin
                  e = exp_q.pop_front();
                  chk("output byte/last", int'({out_last, out_data}), int'(e));
               end
               pops++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_last, out_data};
            prev_ov    = out_valid;
            prev_err   = err;
         end
      end
   end

   initial begin
      int a[25], b[25];
      int base, g;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset in_ready", int'(in_ready), 1);
      chk("reset start", int'(start), 0);
      chk("reset out_valid", int'(out_valid), 0);
      chk("reset out_last", int'(out_last), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset err", int'(err), 0);
      chk_w("reset matrix_a", matrix_a, '0);
      chk_w("reset matrix_b", matrix_b, '0);
      @(posedge clock); #1;
      reset = 1'b0;

      for (int i = 0; i < 25; i++) begin a[i] = (i % 6 == 0) ? 1 : 0; b[i] = i + 1; end
      send_job(a, b, 1'b0);
      wait_idle();
      chk("err after identity job", int'(err), 0);

      for (int i = 0; i < 25; i++) begin a[i] = 2; b[i] = 3; end
      send_job(a, b, 1'b0);
      wait_idle();

      for (int i = 0; i < 25; i++) begin a[i] = 8'h10; b[i] = 8'h10; end
      send_job(a, b, 1'b0);
      wait_idle();

      for (int i = 0; i < 25; i++) begin a[i] = 8'hFF; b[i] = (i % 6 == 0) ? 1 : 0; end
      send_job(a, b, 1'b0);
      wait_idle();

      for (int j = 0; j < 4; j++) begin
         ready_mode = (j == 0) ? 1 : 2;
         for (int i = 0; i < 25; i++) begin a[i] = $urandom_range(0, 255); b[i] = $urandom_range(0, 255); end
         send_job(a, b, 1'b1);
         wait_idle();
      end
      ready_mode = 0;
      chk("err after normal jobs", int'(err), 0);

      kill_done = 1'b1;
      for (int i = 0; i < 25; i++) begin a[i] = $urandom_range(0, 255); b[i] = $urandom_range(0, 255); end
      send_job(a, b, 1'b0);
      wait_idle();
      kill_done = 1'b0;
      chk("err after missing done", int'(err), 1);

      for (int i = 0; i < 25; i++) begin a[i] = $urandom_range(0, 255); b[i] = $urandom_range(0, 255); end
      send_job(a, b, 1'b0);
      wait_idle();
      chk("err sticky across job", int'(err), 1);

      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("err cleared by reset", int'(err), 0);
      @(posedge clock); #1;

      for (int i = 0; i < 25; i++) begin a[i] = $urandom_range(0, 255); b[i] = $urandom_range(0, 255); end
      base = pops;
      send_job(a, b, 1'b0);
      g = 0;
      do begin
         @(negedge clock); #1;
         g++;
      end while (pops - base < 10 && g < 500);
      chk("reached output byte 10", int'(pops - base >= 10), 1);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clock);
      chk("out_valid after mid-drain reset", int'(out_valid), 0);
      chk("in_ready after mid-drain reset", int'(in_ready), 1);
      @(posedge clock); #1;

      for (int i = 0; i < 25; i++) begin a[i] = $urandom_range(0, 255); b[i] = $urandom_range(0, 255); end
      send_job(a, b, 1'b1);
      wait_idle();
      chk("err after fresh job", int'(err), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
